// File: rtl/pwm_multi_if.sv
// Control and output bundle for pwm_multi: shadow-load inputs, polarity and registered PWM outputs.
interface pwm_multi_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
);
  logic                      EN;
  logic                      MODE;
  logic [WIDTH-1:0]          PERIOD;
  logic [CHANNELS*WIDTH-1:0] DUTY;
  logic                      LOAD;
  logic [CHANNELS-1:0]       POLARITY;
  logic [CHANNELS-1:0]       SIGNAL;
  logic                      PERIOD_END;

  modport master (
    output EN, MODE, PERIOD, DUTY, LOAD, POLARITY,
    input  SIGNAL, PERIOD_END
  );

  modport slave (
    input  EN, MODE, PERIOD, DUTY, LOAD, POLARITY,
    output SIGNAL, PERIOD_END
  );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM with one shared edge/center-aligned counter and period-boundary
// shadow loading of mode, period and per-channel duty.
module pwm_multi #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input logic        CLK,
  input logic        RST,
  pwm_multi_if.slave bus
);
  typedef logic [WIDTH-1:0] cnt_t;
  localparam cnt_t One = cnt_t'(1);

  cnt_t                      cnt_q, cnt_d;
  logic                      dir_q, dir_d;  // 1 = counting down (center mode only)
  logic                      mode_q, mode_d;
  cnt_t                      per_q, per_d;
  logic [CHANNELS*WIDTH-1:0] duty_q, duty_d;
  logic                      mode_sh_q, mode_sh_d;
  cnt_t                      per_sh_q, per_sh_d;
  logic [CHANNELS*WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic                      pend_q, pend_d;
  logic [CHANNELS-1:0]       sig_q, sig_d;
  logic                      end_q, end_d;
  logic                      end_cyc;
  logic                      restart;

  always_comb begin
    if (!mode_q) begin
      end_cyc = (cnt_q == per_q);
    end else begin
      end_cyc = (per_q == '0) || ((cnt_q == One) && (dir_q || (per_q == One)));
    end
  end

  // Active registers may only be replaced while idle or on the last count of a period.
  assign restart = !bus.EN || end_cyc;

  always_comb begin
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    mode_d    = mode_q;
    per_d     = per_q;
    duty_d    = duty_q;
    mode_sh_d = mode_sh_q;
    per_sh_d  = per_sh_q;
    duty_sh_d = duty_sh_q;
    pend_d    = pend_q;
    sig_d     = bus.POLARITY;
    end_d     = 1'b0;

    if (bus.LOAD) begin
      mode_sh_d = bus.MODE;
      per_sh_d  = bus.PERIOD;
      duty_sh_d = bus.DUTY;
    end

    if (restart) begin
      cnt_d  = '0;
      dir_d  = 1'b0;
      pend_d = 1'b0;
      // A LOAD coincident with the restart bypasses the shadows.
      if (bus.LOAD) begin
        mode_d = bus.MODE;
        per_d  = bus.PERIOD;
        duty_d = bus.DUTY;
      end else if (pend_q) begin
        mode_d = mode_sh_q;
        per_d  = per_sh_q;
        duty_d = duty_sh_q;
      end
    end else begin
      if (bus.LOAD) begin
        pend_d = 1'b1;
      end
      if (mode_q && dir_q) begin
        cnt_d = cnt_q - One;
      end else begin
        cnt_d = cnt_q + One;
        if (mode_q && (cnt_d == per_q)) begin
          dir_d = 1'b1;
        end
      end
    end

    if (bus.EN) begin
      end_d = end_cyc;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        sig_d[i] = (cnt_q < duty_q[i*WIDTH +: WIDTH]) ^ bus.POLARITY[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      mode_q    <= 1'b0;
      per_q     <= '1;
      duty_q    <= '0;
      mode_sh_q <= 1'b0;
      per_sh_q  <= '1;
      duty_sh_q <= '0;
      pend_q    <= 1'b0;
      sig_q     <= '0;
      end_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      per_q     <= per_d;
      duty_q    <= duty_d;
      mode_sh_q <= mode_sh_d;
      per_sh_q  <= per_sh_d;
      duty_sh_q <= duty_sh_d;
      pend_q    <= pend_d;
      sig_q     <= sig_d;
      end_q     <= end_d;
    end
  end

  assign bus.SIGNAL     = sig_q;
  assign bus.PERIOD_END = end_q;
endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a phase-index reference model queues the expected output
// of every cycle, and directed windows count duty and period-end pulses.
module tb_pwm_multi;
  localparam int W = 8;
  localparam int N = 4;

  logic CLK = 1'b0;
  logic RST;
  pwm_multi_if #(.WIDTH(W), .CHANNELS(N)) bus ();

  pwm_multi #(.WIDTH(W), .CHANNELS(N)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: k is the position within the current period.
  int m_k, m_per, m_mode, m_pend, sh_per, sh_mode;
  int m_duty[N];
  int sh_duty[N];
  logic [N:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic take_inputs();
    m_mode = int'(bus.MODE);
    m_per  = int'(bus.PERIOD);
    for (int i = 0; i < N; i++) m_duty[i] = int'(bus.DUTY[i*W +: W]);
  endtask

  task automatic step();
    logic [N-1:0] es;
    logic         ep;
    logic [N:0]   got;
    int len, c;
    bit endc;
    len  = (m_mode != 0) ? 2 * m_per : m_per + 1;
    if (len == 0) len = 1;
    c    = (m_k <= m_per) ? m_k : 2 * m_per - m_k;
    endc = (m_k == len - 1);
    es   = '0;
    ep   = 1'b0;
    if (RST) begin
      m_k = 0; m_mode = 0; m_per = 255; m_pend = 0; sh_mode = 0; sh_per = 255;
      for (int i = 0; i < N; i++) begin m_duty[i] = 0; sh_duty[i] = 0; end
    end else begin
      if (bus.EN) begin
        for (int i = 0; i < N; i++) es[i] = (c < m_duty[i]) ^ bus.POLARITY[i];
        ep = endc;
      end else begin
        es = bus.POLARITY;
      end
      if (!bus.EN || endc) begin
        m_k = 0;
        if (bus.LOAD) take_inputs();
        else if (m_pend != 0) begin
          m_mode = sh_mode; m_per = sh_per;
          for (int i = 0; i < N; i++) m_duty[i] = sh_duty[i];
        end
        m_pend = 0;
      end else begin
        m_k++;
        if (bus.LOAD) m_pend = 1;
      end
      if (bus.LOAD) begin
        sh_mode = int'(bus.MODE);
        sh_per  = int'(bus.PERIOD);
        for (int i = 0; i < N; i++) sh_duty[i] = int'(bus.DUTY[i*W +: W]);
      end
    end
    exp_q.push_back({es, ep});
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = exp_q.pop_front();
      check("signal", 32'(bus.SIGNAL), 32'(got[N:1]));
      check("period_end", 32'(bus.PERIOD_END), 32'(got[0]));
    end
  endtask

  task automatic load(input logic mode, input logic [W-1:0] per, input logic [N*W-1:0] duty);
    bus.MODE = mode; bus.PERIOD = per; bus.DUTY = duty; bus.LOAD = 1'b1;
    step();
    bus.LOAD = 1'b0;
  endtask

  task automatic window(input int n, input int ch, output int hi, output int pe);
    hi = 0; pe = 0;
    for (int i = 0; i < n; i++) begin
      step();
      hi += int'(bus.SIGNAL[ch]);
      pe += int'(bus.PERIOD_END);
    end
  endtask

  int hi, pe, hi2, pe2;

  initial begin
    m_k = 0; m_per = 255; m_mode = 0; m_pend = 0; sh_per = 255; sh_mode = 0;
    for (int i = 0; i < N; i++) begin m_duty[i] = 0; sh_duty[i] = 0; end
    RST = 1'b1;
    bus.EN = 1'b0; bus.LOAD = 1'b0; bus.MODE = 1'b0; bus.PERIOD = '0;
    bus.DUTY = '0; bus.POLARITY = '0;
    step();
    check("reset_signal", 32'(bus.SIGNAL), 32'd0);
    step();
    RST = 1'b0;

    // Full-scale period, one channel at 25 %.
    load(1'b0, 8'd255, {8'd0, 8'd0, 8'd0, 8'd64});
    bus.EN = 1'b1;
    window(256, 0, hi, pe);
    check("p255_hi", 32'(hi), 32'd64);
    check("p255_pe", 32'(pe), 32'd1);
    window(256, 1, hi, pe);
    check("p255_ch1_low", 32'(hi), 32'd0);

    // P=9 with duty 0 / mid / P+1 / max.
    bus.EN = 1'b0;
    load(1'b0, 8'd9, {8'd255, 8'd10, 8'd5, 8'd0});
    bus.EN = 1'b1;
    window(10, 1, hi, pe);
    check("p9_ch1_hi", 32'(hi), 32'd5);
    check("p9_pe", 32'(pe), 32'd1);
    window(10, 0, hi, pe);
    check("p9_ch0_hi", 32'(hi), 32'd0);
    window(10, 2, hi, pe);
    check("p9_ch2_hi", 32'(hi), 32'd10);
    window(10, 3, hi, pe);
    check("p9_ch3_hi", 32'(hi), 32'd10);

    // Mid-period LOAD only takes effect at the next period.
    bus.EN = 1'b0;
    load(1'b0, 8'd9, {8'd0, 8'd0, 8'd0, 8'd3});
    bus.EN = 1'b1;
    window(4, 0, hi, pe);
    load(1'b0, 8'd9, {8'd0, 8'd0, 8'd0, 8'd7});
    window(5, 0, hi2, pe2);
    check("midload_cur_hi", 32'(hi + hi2), 32'd3);
    window(10, 0, hi, pe);
    check("midload_next_hi", 32'(hi), 32'd7);
    window(10, 0, hi, pe);
    check("midload_after_hi", 32'(hi), 32'd7);

    // Center-aligned P=4.
    bus.EN = 1'b0;
    load(1'b1, 8'd4, {8'd0, 8'd0, 8'd0, 8'd2});
    bus.EN = 1'b1;
    window(8, 0, hi, pe);
    check("center_hi", 32'(hi), 32'd3);
    check("center_pe", 32'(pe), 32'd1);
    window(8, 0, hi, pe);
    check("center_hi2", 32'(hi), 32'd3);

    // Polarity, EN drop and reset mid-period.
    bus.EN = 1'b0;
    load(1'b0, 8'd9, {8'd255, 8'd10, 8'd5, 8'd0});
    bus.POLARITY = 4'b0010;
    bus.EN = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.EN = 1'b0;
    step();
    check("en_drop_signal", 32'(bus.SIGNAL), 32'h2);
    bus.EN = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.LOAD = 1'b1; bus.DUTY = {8'd9, 8'd9, 8'd9, 8'd9};
    step();
    bus.LOAD = 1'b0;
    RST = 1'b1;
    step();
    check("rst_mid_signal", 32'(bus.SIGNAL), 32'h0);
    RST = 1'b0;
    window(256, 1, hi, pe);
    check("rst_dropped_pending", 32'(hi), 32'd256);
    check("rst_p255_pe", 32'(pe), 32'd1);

    // P=0 edge mode.
    bus.EN = 1'b0;
    bus.POLARITY = '0;
    load(1'b0, 8'd0, {8'd0, 8'd0, 8'd0, 8'd1});
    bus.EN = 1'b1;
    window(5, 0, hi, pe);
    check("p0_ch0_hi", 32'(hi), 32'd5);
    check("p0_pe", 32'(pe), 32'd5);
    window(5, 1, hi, pe);
    check("p0_ch1_hi", 32'(hi), 32'd0);

    // Random loads, modes and enable drops against the model.
    for (int i = 0; i < 600; i++) begin
      bus.LOAD     = ($urandom_range(0, 7) == 0);
      bus.MODE     = 1'($urandom_range(0, 1));
      bus.PERIOD   = 8'($urandom_range(0, 12));
      bus.DUTY     = {8'($urandom_range(0, 14)), 8'($urandom_range(0, 14)),
                      8'($urandom_range(0, 14)), 8'($urandom_range(0, 14))};
      bus.POLARITY = 4'($urandom_range(0, 15));
      bus.EN       = ($urandom_range(0, 30) != 0);
      step();
    end
    bus.LOAD = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 Parameter WIDTH, default 8, counter/duty/period bit width (>=2).
REQ-002 Parameter CHANNELS, default 4, number of independent PWM outputs (>=1).
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 EN  in  1  1 = counter runs; 0 = counter held, outputs inactive.
REQ-006 MODE  in  1  0 = edge-aligned, 1 = center-aligned; captured by LOAD.
REQ-007 PERIOD  in  WIDTH  terminal count P; captured by LOAD.
REQ-008 DUTY  in  CHANNELS*WIDTH  channel i duty in bits [i*WIDTH +: WIDTH]; captured by LOAD.
REQ-009 LOAD  in  1  single-cycle strobe; samples MODE, PERIOD, DUTY into shadow registers.
REQ-010 POLARITY  in  CHANNELS  per-channel output inversion, unregistered-through (applied at output register).
REQ-011 SIGNAL  out  CHANNELS  registered PWM outputs.
REQ-012 PERIOD_END  out  1  registered one-cycle pulse marking the last count of each period.

Function
REQ-013 One shared counter c (WIDTH bits) and direction bit d (0 = up) SHALL serve all channels.
REQ-014 Edge mode: c SHALL step 0,1,...,P then return to 0; period = P+1 cycles; P=0 holds c at 0.
REQ-015 Center mode: c SHALL step 0,1,...,P,P-1,...,1 then 0; period = 2P cycles; d flips to down when c reaches P, to up when c reaches 0; P=0 holds c at 0.
REQ-016 End cycle SHALL be: edge c==P; center (c==1 and d down) or P==1 with c==1, or P==0 (every cycle).
REQ-017 Active registers (mode, P, duty[i]) SHALL change only on an end-cycle edge, on EN low, or on reset -- never mid-period.
REQ-018 LOAD SHALL write shadow registers and set a pending flag; on the next end-cycle edge, pending shadows copy to active, pending clears, c goes to 0 with d up.
REQ-019 LOAD coincident with an end cycle SHALL make that cycle's inputs active at the immediately following count 0.
REQ-020 A mode change SHALL take effect only via REQ-018/019, restarting at c=0, d up.
REQ-021 Raw output r[i] = (c < duty[i]), unsigned compare over full WIDTH; duty 0 -> always low; duty > P -> always high (edge); duty > P -> always high (center).
REQ-022 SIGNAL[i] SHALL register r[i] XOR POLARITY[i]; latency one cycle from counter value to output.
REQ-023 PERIOD_END SHALL register the end-cycle condition, aligned with the SIGNAL sample of the last count.
REQ-024 EN low: c held 0, d up, SIGNAL[i] = POLARITY[i], PERIOD_END 0; pending shadows copy to active each cycle; on EN rising, first output cycle corresponds to c=0.
REQ-025 LOAD with EN low SHALL make new values active the next cycle.
REQ-026 Counter arithmetic SHALL not overflow: P = 2^WIDTH-1 wraps exactly to 0 in edge mode.

Reset
REQ-027 RST high at an edge SHALL set c=0, d up, mode 0, active P = 2^WIDTH-1, all active/shadow duty 0, pending 0, SIGNAL all 0, PERIOD_END 0.
REQ-028 RST SHALL override EN and LOAD in the same cycle; reset mid-period discards pending values.

Verification (WIDTH=8, CHANNELS=4)
REQ-029 Reset, EN=0, LOAD DUTY ch0=64 (P=255, MODE 0), EN=1 -> SIGNAL[0] high 64 of every 256 cycles; PERIOD_END every 256 cycles; others low.
REQ-030 P=9 edge, duty {0,5,10,255} -> ch0 constantly low, ch1 5/10 high, ch2 and ch3 constantly high; PERIOD_END period 10.
REQ-031 P=9, duty0=3 running; LOAD duty0=7 at c=4 -> current period 3 cycles high, all following periods 7 high; no glitch at the LOAD cycle.
REQ-032 Center mode P=4, duty0=2 -> c sequence 0,1,2,3,4,3,2,1; SIGNAL[0] high 3 of 8 cycles (c=1,0,1 contiguous across wrap); PERIOD_END period 8.
REQ-033 POLARITY=4'b0010, drop EN mid-period -> next cycle SIGNAL=4'b0010, c=0; assert RST mid-period -> SIGNAL=4'b0000, active P=255, duty 0 next cycle.
REQ-034 P=0 edge, duty0=1, duty1=0 -> SIGNAL[0] constant high, SIGNAL[1] constant low, PERIOD_END constant high.
